// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Connects an instruction requester and a data requester to one shared memory
//   port. Only one transaction is in flight at a time. The accepted request goes
//   to memory as a registered single-cycle pulse. The memory response is passed
//   back to whichever side was granted. If memory does not answer within TIMEOUT
//   cycles, a sticky error is raised and the owner receives 32'hDEAD_BEEF.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN : when defined, simultaneous requests alternate between
//                            the two sides. When undefined, data has fixed priority.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   inst_req     instruction-side request     inst_req_ack  accept pulse
//   inst_rsp     instruction-side response
//   data_req     data-side request            data_req_ack  accept pulse
//   data_rsp     data-side response
//   mem_req      request to shared memory     mem_rsp       response from memory
//   busy         transaction outstanding
//   timeout_err  sticky response-timeout flag
//
// States:
//   state    | meaning
//   IDLE     | no transaction; arbitrate and ack
//   ISSUE    | drive latched request to memory for one cycle
//   WAIT_RSP | wait for mem_rsp or timeout

package mem_port_arbiter_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  do_write;
        logic [31:0] data;
    } memory_io_req;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } memory_io_rsp;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  memory_io_req inst_req,
    output logic         inst_req_ack,
    output memory_io_rsp inst_rsp,
    input  memory_io_req data_req,
    output logic         data_req_ack,
    output memory_io_rsp data_rsp,
    output memory_io_req mem_req,
    input  memory_io_rsp mem_rsp,
    output logic         busy,
    output logic         timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

    state_t      state, state_nxt;
    logic [CW-1:0] cnt;
    logic        owner_data;
    logic [31:0] addr_q;
    logic [3:0]  we_q;
    logic [31:0] data_q;
    logic        err_q;
    logic        grant_any;
    logic        grant_data;
    logic        fire;
    logic        rsp_now;
    logic [31:0] rsp_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic pref_inst;

    // On a tie, inst wins only when it is inst's turn.
    assign grant_data = data_req.valid & (~inst_req.valid | ~pref_inst);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pref_inst <= 1'b1;
        else if (state == IDLE && grant_any)
            pref_inst <= grant_data;
    end
`else
    assign grant_data = data_req.valid;
`endif

    assign grant_any = inst_req.valid | data_req.valid;

    // cnt counts WAIT_RSP cycles already spent. The TIMEOUT-th waiting cycle is
    // the terminal one. A real response in that same cycle takes priority.
    assign fire    = (state == WAIT_RSP) && !mem_rsp.valid && (cnt == CW'(TIMEOUT - 1));
    assign rsp_now = (state == WAIT_RSP) && (mem_rsp.valid || fire);
    assign rsp_data = mem_rsp.valid ? mem_rsp.data : 32'hDEAD_BEEF;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        inst_req_ack = 1'b0;
        data_req_ack = 1'b0;
        mem_req      = '0;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    data_req_ack = grant_data;
                    inst_req_ack = ~grant_data;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                mem_req.valid    = 1'b1;
                mem_req.addr     = addr_q;
                mem_req.do_write = we_q;
                mem_req.data     = data_q;
                state_nxt        = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_now)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        inst_rsp = '0;
        data_rsp = '0;
        if (rsp_now) begin
            if (owner_data) begin
                data_rsp.valid = 1'b1;
                data_rsp.data  = rsp_data;
            end else begin
                inst_rsp.valid = 1'b1;
                inst_rsp.data  = rsp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_data <= 1'b1;
            addr_q     <= '0;
            we_q       <= '0;
            data_q     <= '0;
        end else if (state == IDLE && grant_any) begin
            owner_data <= grant_data;
            addr_q     <= grant_data ? data_req.addr     : inst_req.addr;
            we_q       <= grant_data ? data_req.do_write : inst_req.do_write;
            data_q     <= grant_data ? data_req.data     : inst_req.data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT_RSP && cnt != CW'(TIMEOUT))
                cnt <= cnt + 1'b1;
            if (fire)
                err_q <= 1'b1;
        end
    end

    assign busy = (state != IDLE);
    // The flag rises during the terminal cycle itself, alongside the DEAD_BEEF response.
    assign timeout_err = err_q | fire;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. The DUT is built with TIMEOUT = 4.
// It runs directed table vectors, multi-cycle corner sequences, and a randomized
// run checked against a transaction-timing model.

module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    memory_io_req inst_req, data_req, mem_req;
    memory_io_rsp inst_rsp, data_rsp, mem_rsp;
    logic         inst_req_ack, data_req_ack, busy, timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_req_ack (inst_req_ack),
        .inst_rsp     (inst_rsp),
        .data_req     (data_req),
        .data_req_ack (data_req_ack),
        .data_rsp     (data_rsp),
        .mem_req      (mem_req),
        .mem_rsp      (mem_rsp),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    typedef struct {
        bit          side_data;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        logic [31:0] exp_rsp;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic memory_io_req mk_req(input logic [31:0] a, input logic [3:0] w,
                                            input logic [31:0] d);
        memory_io_req r;
        r.valid = 1'b1;
        r.addr = a;
        r.do_write = w;
        r.data = d;
        return r;
    endfunction

    function automatic memory_io_req rand_req();
        return mk_req($urandom, 4'($urandom_range(0, 15)), $urandom);
    endfunction

    task automatic idle_inputs();
        inst_req = '0;
        data_req = '0;
        mem_rsp  = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_acks"}, 128'({inst_req_ack, data_req_ack}), 128'(2'b00));
        chk({tag, "_mem_req"}, 128'(mem_req), 128'(0));
        chk({tag, "_inst_rsp"}, 128'(inst_rsp), 128'(0));
        chk({tag, "_data_rsp"}, 128'(data_rsp), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_err"}, 128'(timeout_err), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_txn(input vec_t v);
        memory_io_req r;
        memory_io_rsp own, oth;
        r = mk_req(v.addr, v.we, v.wdata);
        @(negedge clk);
        idle_inputs();
        if (v.side_data) data_req = r; else inst_req = r;
        #1;
        chk("txn_ack", 128'({inst_req_ack, data_req_ack}), 128'(v.side_data ? 2'b01 : 2'b10));
        chk("txn_busy_idle", 128'(busy), 128'(0));
        @(negedge clk);
        inst_req = '0;
        data_req = '0;
        #1;
        chk("txn_mem_req", 128'(mem_req), 128'(r));
        chk("txn_busy", 128'(busy), 128'(1));
        for (int k = 1; k < v.dly; k++) begin
            @(negedge clk);
            #1;
            chk("txn_mem_req_once", 128'(mem_req.valid), 128'(0));
            chk("txn_rsp_early", 128'({inst_rsp.valid, data_rsp.valid}), 128'(0));
        end
        @(negedge clk);
        mem_rsp.valid = 1'b1;
        mem_rsp.data = v.rdata;
        #1;
        own = v.side_data ? data_rsp : inst_rsp;
        oth = v.side_data ? inst_rsp : data_rsp;
        chk("txn_rsp", 128'(own), 128'({1'b1, v.exp_rsp}));
        chk("txn_other_rsp", 128'(oth.valid), 128'(0));
        chk("txn_err", 128'(timeout_err), 128'(v.exp_err));
        @(negedge clk);
        mem_rsp = '0;
        #1;
        chk("txn_done_busy", 128'(busy), 128'(0));
        chk("txn_done_rsp", 128'({inst_rsp.valid, data_rsp.valid}), 128'(0));
    endtask

    vec_t vecs[5];

    // Randomized run: model state
    bit           p_inst, p_data, m_free, m_own_data, m_pref_inst, win_data, any;
    memory_io_req q_inst, q_data, m_pay, exp_mem;
    memory_io_rsp exp_i, exp_d;
    logic [31:0]  m_rdata;
    int           m_issue, m_rsp;

    initial begin
        vec_t tv;
        memory_io_req ri, rd;
        bit exp_dw;

        idle_inputs();
        vecs[0] = '{1'b0, 32'h0001_0000, 4'b0000, 32'h0,  2,  32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[1] = '{1'b1, 32'h0002_FFF8, 4'b1111, 32'h41, 1,  32'h0,         32'h0,         1'b0};
        vecs[2] = '{1'b1, 32'h8000_0004, 4'b0011, 32'hCAFE_0001, 3, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0100, 4'b0000, 32'h0,  TO, 32'h600D_F00D, 32'h600D_F00D, 1'b0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 4'b1000, 32'hFFFF_FFFF, TO, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0};

        #2;
        check_reset_vals("por");
        do_reset();

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Contention: both sides hold requests for 6 grants.
        do_reset();
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            mem_rsp = '0;
            ri = mk_req(32'h1000 + g, 4'h0, 32'h0);
            rd = mk_req(32'h2000 + g, 4'hF, 32'h77 + g);
            inst_req = ri;
            data_req = rd;
            #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_dw = (g % 2) == 1;
`else
            exp_dw = 1'b1;
`endif
            chk("cont_grant", 128'({inst_req_ack, data_req_ack}), 128'(exp_dw ? 2'b01 : 2'b10));
            @(negedge clk);
            #1;
            chk("cont_no_ack", 128'({inst_req_ack, data_req_ack}), 128'(0));
            chk("cont_mem_req", 128'(mem_req), 128'(exp_dw ? rd : ri));
            @(negedge clk);
            mem_rsp.valid = 1'b1;
            mem_rsp.data = 32'h5000 + g;
            #1;
            chk("cont_rsp", 128'({inst_rsp.valid, data_rsp.valid}), 128'(exp_dw ? 2'b01 : 2'b10));
        end
        @(negedge clk);
        idle_inputs();

        // Timeout with no response from memory.
        do_reset();
        @(negedge clk);
        data_req = mk_req(32'h3000, 4'h0, 32'h0);
        #1;
        chk("to_ack", 128'(data_req_ack), 128'(1));
        @(negedge clk);
        data_req = '0;
        #1;
        chk("to_issue", 128'(mem_req.valid), 128'(1));
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            #1;
            chk("to_err_early", 128'(timeout_err), 128'(0));
            chk("to_rsp_early", 128'({inst_rsp.valid, data_rsp.valid}), 128'(0));
        end
        @(negedge clk);
        #1;
        chk("to_rsp", 128'(data_rsp), 128'({1'b1, 32'hDEAD_BEEF}));
        chk("to_inst_rsp", 128'(inst_rsp.valid), 128'(0));
        chk("to_err", 128'(timeout_err), 128'(1));
        @(negedge clk);
        #1;
        chk("to_idle", 128'(busy), 128'(0));
        chk("to_sticky", 128'(timeout_err), 128'(1));
        tv = '{1'b0, 32'h0000_0040, 4'h0, 32'h0, 2, 32'h1111_2222, 32'h1111_2222, 1'b1};
        run_txn(tv);

        // Reset in WAIT_RSP, then a stray response.
        do_reset();
        @(negedge clk);
        inst_req = mk_req(32'h4000, 4'h0, 32'h0);
        @(negedge clk);
        inst_req = '0;
        @(negedge clk);
        #1;
        chk("rst_mid_busy", 128'(busy), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mem_rsp.valid = 1'b1;
        mem_rsp.data = 32'h9999_9999;
        #1;
        chk("stray_rsp", 128'({inst_rsp.valid, data_rsp.valid}), 128'(0));
        chk("stray_busy", 128'(busy), 128'(0));
        chk("stray_mem_req", 128'(mem_req), 128'(0));
        @(negedge clk);
        mem_rsp = '0;

        // Randomized traffic against the transaction-timing model.
        do_reset();
        p_inst = 0; p_data = 0; m_free = 1; m_pref_inst = 1;
        m_issue = -1; m_rsp = -1; m_own_data = 0; m_pay = '0; m_rdata = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!p_inst && $urandom_range(0, 1) == 1) begin q_inst = rand_req(); p_inst = 1; end
            if (!p_data && $urandom_range(0, 1) == 1) begin q_data = rand_req(); p_data = 1; end
            inst_req = p_inst ? q_inst : '0;
            data_req = p_data ? q_data : '0;
            mem_rsp = '0;
            if (!m_free && c == m_rsp) begin
                m_rdata = $urandom;
                mem_rsp.valid = 1'b1;
                mem_rsp.data = m_rdata;
            end else if (m_free && $urandom_range(0, 7) == 0) begin
                mem_rsp.valid = 1'b1;
                mem_rsp.data = $urandom;
            end
            #1;
            any = m_free && (p_inst || p_data);
            if (p_inst && p_data) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                win_data = !m_pref_inst;
`else
                win_data = 1'b1;
`endif
            end else begin
                win_data = p_data;
            end
            chk("rand_ack", 128'({inst_req_ack, data_req_ack}),
                128'(any ? (win_data ? 2'b01 : 2'b10) : 2'b00));
            exp_mem = (!m_free && c == m_issue) ? m_pay : '0;
            chk("rand_mem_req", 128'(mem_req), 128'(exp_mem));
            exp_i = '0;
            exp_d = '0;
            if (!m_free && c == m_rsp) begin
                if (m_own_data) exp_d = {1'b1, m_rdata};
                else            exp_i = {1'b1, m_rdata};
            end
            chk("rand_inst_rsp", 128'(inst_rsp), 128'(exp_i));
            chk("rand_data_rsp", 128'(data_rsp), 128'(exp_d));
            chk("rand_busy", 128'(busy), 128'(!m_free));
            chk("rand_err", 128'(timeout_err), 128'(0));
            if (!m_free && c == m_rsp) begin
                m_free = 1;
            end else if (any) begin
                m_free = 0;
                m_issue = c + 1;
                m_rsp = c + 1 + int'($urandom_range(1, TO));
                m_own_data = win_data;
                m_pay = win_data ? q_data : q_inst;
                if (win_data) p_data = 0; else p_inst = 0;
                m_pref_inst = win_data;
            end
        end
        @(negedge clk);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one `memory` port between an instruction requester and a data requester, e.g. `core32` fetch and load/store on a unified code+data memory.
- Accepts at most one transaction at a time, forwards it to memory as a registered single-cycle request, and routes the response back to the granted requester.
- Adds a response timeout that raises a sticky error.

## Interface

Parameters:
- `TIMEOUT`, default 64: cycles to wait for `mem_rsp.valid` before declaring an error; minimum 2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to `clk`.
- `inst_req`  in  memory_io_req  instruction-side request; fields used: `valid`, `addr[31:0]`, `do_write[3:0]`, `data[31:0]`.
- `inst_req_ack`  out  1  one-cycle pulse: the `inst_req` present this cycle is accepted.
- `inst_rsp`  out  memory_io_rsp  response to the instruction side; `valid` pulses once per accepted inst request.
- `data_req`  in  memory_io_req  data-side request; same fields as `inst_req`.
- `data_req_ack`  out  1  one-cycle pulse: the `data_req` present this cycle is accepted.
- `data_rsp`  out  memory_io_rsp  response to the data side.
- `mem_req`  out  memory_io_req  request to the shared memory.
- `mem_rsp`  in  memory_io_rsp  response from memory; exactly one `valid` pulse per request, writes included.
- `busy`  out  1  high while a transaction is outstanding (state is not IDLE).
- `timeout_err`  out  1  sticky; set on response timeout, cleared only by reset.

## Operation

States: IDLE, ISSUE, WAIT_RSP.

- **IDLE:** if either `req.valid` is high, select a winner, pulse its `*_req_ack`, latch its addr/do_write/data and the grant owner, then go to ISSUE. If neither is valid, stay in IDLE.
- **ISSUE:** drive `mem_req` from the latched values with `mem_req.valid` = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT_RSP.
- **WAIT_RSP:** `mem_req.valid` = 0.
  - On `mem_rsp.valid`: copy `mem_rsp` to the owner's `*_rsp` with `valid` = 1 that same cycle (combinational pass-through). The other side's `rsp.valid` stays 0. Go to IDLE.
  - Otherwise the counter increments. When it reaches `TIMEOUT`: set `timeout_err`, pulse the owner's `rsp.valid` with data = 32'hDEAD_BEEF, and go to IDLE.
- `mem_rsp.valid` in IDLE or ISSUE is ignored; it is not forwarded.
- Requester contract: hold `valid` and the payload until ack. A request that drops `valid` before ack is simply never issued.
- The latched payload is unaffected by requester changes after ack.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide and saturates; it never wraps.

## Timing

- Reset values: state = IDLE; `mem_req` all fields 0; both acks 0; both `rsp.valid` 0 with rsp data 0; `busy` = 0; `timeout_err` = 0; owner = data; round-robin pointer = inst-preferred.
- Ack to `mem_req.valid`: 1 cycle. Request in cycle T is acked in T, and `mem_req.valid` is high in T+1.
- Minimum round trip is 3 cycles: ack in T, issue in T+1, `mem_rsp` earliest in T+2 with `rsp` in T+2. The next ack is possible in T+3.
- Acks never occur outside IDLE, so there is never more than one outstanding transaction.
- Reset asserted mid-transaction: return to IDLE at once and drop the transaction. A late `mem_rsp` after reset release is ignored because state is IDLE.
- Simultaneous `mem_rsp.valid` and timeout terminal count in the same cycle: the real response wins and `timeout_err` is not set.

## Configuration

- `MEM_ARB_ROUND_ROBIN_EN` defined: when both sides request in the same IDLE cycle, the side not granted last time wins. The pointer updates on every grant.
- Undefined: fixed priority, data beats inst. Instruction requests are served only when `data_req.valid` = 0.
- Single-requester behaviour is identical in both builds.

## Test plan

- **Single read:** `inst_req` addr 32'h0001_0000 read; memory returns 32'h1234_5678 two cycles after `mem_req`. Required: ack at T, `mem_req.valid` at T+1, `inst_rsp.valid` with data 32'h1234_5678 at T+3, and `data_rsp.valid` stays 0.
- **Write pass-through:** `data_req` addr 32'h0002_FFF8, do_write 4'b1111, data 32'h41. Required: `mem_req` carries identical addr/do_write/data for exactly one cycle, and `data_rsp.valid` pulses once.
- **Contention:** both sides request continuously for 6 transactions.
  - With `MEM_ARB_ROUND_ROBIN_EN`: grants alternate inst, data, inst, and so on.
  - Without it: all 6 grants go to data while `data_req.valid` is held.
- **Timeout:** `TIMEOUT` = 4, memory never responds. Required: `timeout_err` rises 4 cycles after issue; the owner receives `rsp.valid` with 32'hDEAD_BEEF; state returns to IDLE; the next request proceeds normally with `timeout_err` still 1.
- **Reset mid-op:** assert `reset` (low) in WAIT_RSP, release, then deliver a stray `mem_rsp.valid`. Required: all outputs at reset values, no `rsp.valid` to either side, `busy` = 0.
- **Race:** `mem_rsp.valid` arrives on the exact terminal-count cycle. Required: real data forwarded and `timeout_err` stays 0.
